imm_extend_unit: RTL and testbench
==================================

Name: imm_extend_unit

Overview:
- Sequential immediate extender for the ARM datapath.
- Accepts a 24-bit instruction immediate field and a 2-bit mode; produces a WIDTH-bit extended immediate and a shifter-carry update.
- Rotated data-processing immediates are produced by an iterative rotator, fixed ROT_STEP bits per cycle.
- Sits between decode and the execute operand mux; valid/ready on both sides.

Parameters:
- WIDTH, 32, output data width; must be >= 26.
- ROT_STEP, 2, bits rotated right per ROTATE cycle; legal values 1 or 2.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- instr_imm  input  24  instruction bits [23:0]
- imm_src  input  2  00 rot-imm8, 01 imm12 zero-ext, 10 imm24 branch, 11 reserved
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- ext_imm  output  WIDTH  extended immediate
- carry_upd  output  1  result came from a nonzero rotation
- carry_out  output  1  shifter carry, ext_imm[WIDTH-1] when carry_upd=1, else 0

Behaviour:
- Reset state:
  - state=IDLE, in_ready=1, out_valid=0, ext_imm=0, carry_upd=0, carry_out=0.
  - reset in any state aborts the in-flight request and returns to this state on the next edge.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture the request. Mode 00 with rot!=0 goes to ROTATE; all other modes go to HOLD.
  - ROTATE: in_ready=0, out_valid=0. Each cycle, acc = acc ROR ROT_STEP and cnt decrements. When cnt reaches 1, go to HOLD.
  - HOLD: out_valid=1, outputs stable. On out_ready, go to IDLE. No new request is accepted in the same cycle (in_ready=0 in HOLD).
- Mode 00 (rotated imm8):
  - imm8=instr_imm[7:0], rot=instr_imm[11:8].
  - Result = zero-extended imm8 rotated right by 2*rot within WIDTH bits.
  - cnt loaded with 2*rot/ROT_STEP.
  - carry_upd=(rot!=0), carry_out=result[WIDTH-1] when carry_upd=1.
- Mode 01: ext_imm = zero-extended instr_imm[11:0]; carry_upd=0.
- Mode 10: ext_imm = sign-extended {instr_imm[23:0], 2'b00}; carry_upd=0.
- Mode 11: ext_imm=0, carry_upd=0, accepted normally.
- Latency, accept edge to out_valid:
  - 1 cycle for modes 01/10/11 and for mode 00 with rot=0.
  - 1+2*rot/ROT_STEP cycles for mode 00 with rot!=0.
- Throughput: at most one request per (latency+1) cycles. Back-to-back accept is not permitted.
- Signals with in_valid=0 are ignored. instr_imm/imm_src are sampled only at the accept edge; later changes have no effect.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: IMM_EXTEND_BARREL_EN.
- Defined: the rotation is computed combinationally at capture, ROTATE is never entered, and every mode has 1-cycle latency. Outputs are otherwise identical.
- Undefined: iterative ROTATE behaviour as above.

Decomposition:
- extend_pkg holds:
  - imm_src_e enum (IMM_ROT8, IMM_12, IMM_BR24, IMM_RSVD).
  - state_e enum (IDLE, ROTATE, HOLD).
  - Field position constants (ROT_MSB=11, ROT_LSB=8).
- One sub-module, ror_step: combinational WIDTH-bit rotate-right by ROT_STEP, instantiated once in the accumulator path.

Test Plan (WIDTH=32, ROT_STEP=2):
- imm_src=01, instr_imm=24'h000fff, out_ready=1 -> ext_imm=32'h00000fff, carry_upd=0, out_valid exactly 1 cycle after accept.
- imm_src=00, instr_imm=24'h0004ff (rot=4) -> ext_imm=32'hff000000, carry_upd=1, carry_out=1, out_valid 5 cycles after accept; in_ready=0 throughout. With IMM_EXTEND_BARREL_EN defined, the same values appear after 1 cycle.
- imm_src=00, instr_imm=24'h0000ab (rot=0) -> ext_imm=32'h000000ab, carry_upd=0, carry_out=0, 1-cycle latency.
- imm_src=10, instr_imm=24'hfffffe -> ext_imm=32'hfffffff8. Then imm_src=10, instr_imm=24'h000001 -> ext_imm=32'h00000004.
- Backpressure: mode 01 result with out_ready=0 for 3 cycles -> out_valid and ext_imm held stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- reset=1 during ROTATE of instr_imm=24'h000f01 -> next edge: out_valid=0, in_ready=1, ext_imm=0. Then imm_src=11 -> ext_imm=0 after 1 cycle.

Source files
------------

// File: rtl/extend_pkg.sv
// Shared types and field positions for the immediate extender.
package extend_pkg;

    typedef enum logic [1:0] {
        IMM_ROT8 = 2'b00,
        IMM_12   = 2'b01,
        IMM_BR24 = 2'b10,
        IMM_RSVD = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int unsigned ROT_MSB  = 11;
    localparam int unsigned ROT_LSB  = 8;
    localparam int unsigned IMM8_MSB = 7;

endpackage

// File: rtl/ror_step.sv
// Fixed-distance rotate-right used by the iterative accumulator.
module ror_step #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ROT_STEP = 2
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    assign q_o = {d_i[ROT_STEP-1:0], d_i[WIDTH-1:ROT_STEP]};

endmodule

// File: rtl/imm_extend_unit.sv
// Sequential ARM immediate extender with valid/ready on both sides.
// IMM_EXTEND_BARREL_EN: rotate at capture instead of iterating in ROTATE.
module imm_extend_unit
    import extend_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ROT_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      instr_imm,
    input  logic [1:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ext_imm,
    output logic             carry_upd,
    output logic             carry_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             cupd_q, cupd_d;

    logic [WIDTH-1:0] acc_ror;
    logic [WIDTH-1:0] imm8_ext;
    logic [WIDTH-1:0] imm12_ext;
    logic [WIDTH-1:0] br_ext;
    logic [25:0]      br_raw;
    logic [4:0]       rot_x2;
    logic [4:0]       cnt_load;
    logic             rot_nz;

    ror_step #(
        .WIDTH    (WIDTH),
        .ROT_STEP (ROT_STEP)
    ) u_ror_step (
        .d_i (acc_q),
        .q_o (acc_ror)
    );

    assign imm8_ext  = WIDTH'(instr_imm[IMM8_MSB:0]);
    assign imm12_ext = WIDTH'(instr_imm[ROT_MSB:0]);
    assign br_raw    = {instr_imm, 2'b00};
    assign br_ext    = WIDTH'($signed(br_raw));
    assign rot_x2    = {instr_imm[ROT_MSB:ROT_LSB], 1'b0};
    assign cnt_load  = rot_x2 / 5'(ROT_STEP);
    assign rot_nz    = (instr_imm[ROT_MSB:ROT_LSB] != 4'd0);

`ifdef IMM_EXTEND_BARREL_EN
    logic [WIDTH-1:0] rot_full;
    // Shift by WIDTH yields zero, so rot_x2 == 0 needs no special case.
    assign rot_full = (imm8_ext >> rot_x2) | (imm8_ext << (32'(WIDTH) - 32'(rot_x2)));
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cupd_d  = cupd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d   = cnt_load;
                    cupd_d  = 1'b0;
                    state_d = HOLD;
                    unique case (imm_src_e'(imm_src))
                        IMM_ROT8: begin
                            cupd_d = rot_nz;
`ifdef IMM_EXTEND_BARREL_EN
                            acc_d  = rot_full;
`else
                            acc_d  = imm8_ext;
                            if (rot_nz) state_d = ROTATE;
`endif
                        end
                        IMM_12:   acc_d = imm12_ext;
                        IMM_BR24: acc_d = br_ext;
                        IMM_RSVD: acc_d = '0;
                    endcase
                end
            end
            ROTATE: begin
                acc_d = acc_ror;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            cupd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cupd_q  <= cupd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign ext_imm   = acc_q;
    assign carry_upd = cupd_q;
    assign carry_out = cupd_q & acc_q[WIDTH-1];

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed self-checking bench for imm_extend_unit (WIDTH=32, ROT_STEP=2).
module tb_imm_extend_unit;

    localparam int unsigned W    = 32;
    localparam int unsigned STEP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   instr_imm;
    logic [1:0]    imm_src;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ext_imm;
    logic          carry_upd;
    logic          carry_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_ext;
    logic        exp_cupd;
    logic        exp_live = 1'b0;

    imm_extend_unit #(
        .WIDTH    (W),
        .ROT_STEP (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_imm (instr_imm),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_imm   (ext_imm),
        .carry_upd (carry_upd),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference behaviour from the mode rules, using plain arithmetic.
    function automatic logic [31:0] m_ext(input logic [1:0] s, input logic [23:0] f);
        longint unsigned v;
        int unsigned     r;
        case (s)
            2'b00: begin
                v = longint'(f[7:0]);
                r = 2 * int'(f[11:8]);
                v = ((v >> r) | (v << (32 - r))) & 64'hffff_ffff;
                return v[31:0];
            end
            2'b01:   return {20'd0, f[11:0]};
            2'b10:   return (f[23] ? 32'hfc00_0000 : 32'h0) | ({8'd0, f} * 32'd4);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int m_lat(input logic [1:0] s, input logic [23:0] f);
`ifdef IMM_EXTEND_BARREL_EN
        return 1;
`else
        if (s == 2'b00 && f[11:8] != 4'd0) return 1 + (2 * int'(f[11:8])) / int'(STEP);
        return 1;
`endif
    endfunction

    // Every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!exp_live) chk("unexpected_valid", 32'(out_valid), 32'h0);
            else begin
                chk("model_ext", ext_imm, exp_ext);
                chk("model_cupd", 32'(carry_upd), 32'(exp_cupd));
                chk("model_cout", 32'(carry_out), exp_cupd ? 32'(exp_ext[31]) : 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (!in_ready && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", 32'(in_ready), 32'h1);
    endtask

    task automatic issue(input logic [1:0] s, input logic [23:0] f);
        wait_idle();
        in_valid  = 1'b1;
        imm_src   = s;
        instr_imm = f;
        exp_ext   = m_ext(s, f);
        exp_cupd  = (s == 2'b00) && (f[11:8] != 4'd0);
        exp_live  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        instr_imm = 24'($urandom);
        imm_src   = 2'($urandom_range(3));
    endtask

    task automatic do_req(input logic [1:0] s, input logic [23:0] f, input logic [31:0] lit,
                          input int hold, input bit early);
        int lat;
        out_ready = early;
        issue(s, f);
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk("busy_in_ready", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(m_lat(s, f)));
        chk("literal_ext", ext_imm, lit);
        chk("hold_in_ready", 32'(in_ready), 32'h0);
        if (!early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_out_valid", 32'(out_valid), 32'h1);
                chk("bp_in_ready", 32'(in_ready), 32'h0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_live  = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'h0);
        chk("release_in_ready", 32'(in_ready), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr_imm = '0;
        imm_src   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_ext_imm", ext_imm, 32'h0);
        chk("rst_carry_upd", 32'(carry_upd), 32'h0);
        chk("rst_carry_out", 32'(carry_out), 32'h0);
        reset = 1'b0;

        do_req(2'b01, 24'h000fff, 32'h0000_0fff, 0, 1'b1);
        do_req(2'b00, 24'h0004ff, 32'hff00_0000, 0, 1'b0);
        do_req(2'b00, 24'h0000ab, 32'h0000_00ab, 0, 1'b0);
        do_req(2'b10, 24'hfffffe, 32'hffff_fff8, 0, 1'b0);
        do_req(2'b10, 24'h000001, 32'h0000_0004, 0, 1'b0);
        do_req(2'b01, 24'h000123, 32'h0000_0123, 3, 1'b0);
        do_req(2'b00, 24'h000a3c, 32'h0003_c000, 1, 1'b1);
        do_req(2'b00, 24'h000102, 32'h8000_0000, 2, 1'b0);
        do_req(2'b01, 24'hffffff, 32'h0000_0fff, 0, 1'b0);
        do_req(2'b10, 24'h800000, 32'hfe00_0000, 0, 1'b1);

        // Abort a long rotation with reset.
        out_ready = 1'b0;
        issue(2'b00, 24'h000f01);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        exp_live = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_ext_imm", ext_imm, 32'h0);
        chk("abort_carry_upd", 32'(carry_upd), 32'h0);
        reset = 1'b0;

        do_req(2'b11, 24'hffffff, 32'h0000_0000, 0, 1'b0);
        do_req(2'b00, 24'h000f01, 32'h0000_0004, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
